cache_mem_arbiter: RTL

//  Shares the single burst memory port (mem_read/mem_write/mem_address/mem_wdata/mem_rdata/mem_resp)

---
 rtl/cache_mem_arbiter_pkg.sv | 19 +
 rtl/cache_mem_arbiter_if.sv | 44 ++++
 rtl/cache_mem_arbiter_sat_counter.sv | 30 +++
 rtl/cache_mem_arbiter.sv | 129 ++++++++++++
 4 files changed

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and default widths for the icache/dcache memory-port arbiter.
// FSM encodings are plain constants so older tooling can consume the package unchanged.
package cache_mem_arbiter_pkg;

  localparam int unsigned ARB_ADDR_WIDTH = 32;
  localparam int unsigned ARB_LINE_WIDTH = 256;
  localparam int unsigned ARB_CNT_WIDTH  = 32;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ARB_IDLE    = 2'd0;
  localparam arb_state_t ARB_GRANT_I = 2'd1;
  localparam arb_state_t ARB_GRANT_D = 2'd2;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } arb_req_t;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Cache-side and adaptor-side line-transfer signals of the memory arbiter.
// slave is the arbiter's view; master is the view of the surrounding caches and adaptor.
interface cache_mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 256
);
  logic                  i_mem_read;
  logic [ADDR_WIDTH-1:0] i_mem_address;
  logic [LINE_WIDTH-1:0] i_mem_rdata;
  logic                  i_mem_resp;

  logic                  d_mem_read;
  logic                  d_mem_write;
  logic [ADDR_WIDTH-1:0] d_mem_address;
  logic [LINE_WIDTH-1:0] d_mem_wdata;
  logic [LINE_WIDTH-1:0] d_mem_rdata;
  logic                  d_mem_resp;

  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [LINE_WIDTH-1:0] mem_wdata;
  logic [LINE_WIDTH-1:0] mem_rdata;
  logic                  mem_resp;

  modport slave (
    input  i_mem_read, i_mem_address,
    output i_mem_rdata, i_mem_resp,
    input  d_mem_read, d_mem_write, d_mem_address, d_mem_wdata,
    output d_mem_rdata, d_mem_resp,
    output mem_read, mem_write, mem_address, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport master (
    output i_mem_read, i_mem_address,
    input  i_mem_rdata, i_mem_resp,
    output d_mem_read, d_mem_write, d_mem_address, d_mem_wdata,
    input  d_mem_rdata, d_mem_resp,
    input  mem_read, mem_write, mem_address, mem_wdata,
    output mem_rdata, mem_resp
  );

endinterface

// File: rtl/cache_mem_arbiter_sat_counter.sv
// Saturating up-counter for arbiter performance statistics; sticks at all-ones.
module cache_mem_arbiter_sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one burst memory port between icache and dcache.
// Each grant latches the whole request and holds it until the adaptor answers.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ARB_ADDR_WIDTH,
  parameter int unsigned LINE_WIDTH = ARB_LINE_WIDTH,
  parameter int unsigned CNT_WIDTH  = ARB_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_mem_arbiter_if.slave   bus,
  output logic [CNT_WIDTH-1:0] i_grant_cnt,
  output logic [CNT_WIDTH-1:0] d_grant_cnt,
  output logic [CNT_WIDTH-1:0] conflict_cnt
);

  arb_state_t            state_q, state_d;
  arb_req_t              last_q, last_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;

  logic i_req, d_req, grant_i, grant_d;
  logic i_inc, d_inc, conflict_inc;
  logic i_resp, d_resp, busy;

  assign i_req = bus.i_mem_read;
  // A simultaneous read and write from the dcache is resolved as a write below.
  assign d_req = bus.d_mem_read | bus.d_mem_write;

  // On a tie, the side that did not win last time goes next.
  assign grant_d = d_req & (~i_req | (last_q == REQ_I));
  assign grant_i = i_req & (~d_req | (last_q == REQ_D));

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    i_inc        = 1'b0;
    d_inc        = 1'b0;
    conflict_inc = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        conflict_inc = i_req & d_req;
        if (grant_d) begin
          state_d = ARB_GRANT_D;
          last_d  = REQ_D;
          addr_d  = bus.d_mem_address;
          wdata_d = bus.d_mem_wdata;
          write_d = bus.d_mem_write;
          d_inc   = 1'b1;
        end else if (grant_i) begin
          state_d = ARB_GRANT_I;
          last_d  = REQ_I;
          addr_d  = bus.i_mem_address;
          write_d = 1'b0;
          i_inc   = 1'b1;
        end
      end
      ARB_GRANT_I, ARB_GRANT_D: begin
        if (bus.mem_resp) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      last_q  <= REQ_I;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
    end
  end

  assign busy            = (state_q == ARB_GRANT_I) | (state_q == ARB_GRANT_D);
  assign bus.mem_read    = busy & ~write_q;
  assign bus.mem_write   = busy & write_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_wdata   = wdata_q;

  // Responses are forwarded combinationally; a stray mem_resp while idle goes nowhere.
  assign i_resp          = (state_q == ARB_GRANT_I) & bus.mem_resp;
  assign d_resp          = (state_q == ARB_GRANT_D) & bus.mem_resp;
  assign bus.i_mem_resp  = i_resp;
  assign bus.d_mem_resp  = d_resp;
  assign bus.i_mem_rdata = i_resp ? bus.mem_rdata : '0;
  assign bus.d_mem_rdata = d_resp ? bus.mem_rdata : '0;

  cache_mem_arbiter_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_i_grant_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .inc_i  (i_inc),
    .cnt_o  (i_grant_cnt)
  );

  cache_mem_arbiter_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_d_grant_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .inc_i  (d_inc),
    .cnt_o  (d_grant_cnt)
  );

  cache_mem_arbiter_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_conflict_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .inc_i  (conflict_inc),
    .cnt_o  (conflict_cnt)
  );

endmodule
